// File: rtl/mc_port_arbiter.sv
// Round-robin arbiter that shares one memory controller between NUM_PORTS requesters,
// holding the controller buses for the whole transaction and timing out hung accesses.
module mc_port_arbiter #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PORTS-1:0]    portReqValid,
  input  logic [NUM_PORTS-1:0]    portWrite,
  input  logic [32*NUM_PORTS-1:0] portAddr,
  input  logic [32*NUM_PORTS-1:0] portWData,
  input  logic [NUM_PORTS-1:0]    portVirtual,
  input  logic [NUM_PORTS-1:0]    portExec,
  output logic [NUM_PORTS-1:0]    portAccept,
  output logic [NUM_PORTS-1:0]    portRspValid,
  output logic                    portRspError,
  output logic [31:0]             portRspData,
  output logic [31:0]             mcRamAddress,
  output logic [31:0]             mcRamIn,
  output logic                    mcReadReq,
  output logic                    mcWriteReq,
  output logic                    mcAddrVirtual,
  output logic                    mcExecMode,
  input  logic [31:0]             mcRamOut,
  input  logic [1:0]              mcStatus,
  output logic                    arbBusy,
  output logic                    timeoutFlag
);

  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [GW-1:0]  lastGrant;
  logic [CW-1:0]  counter;
  logic           guard;
  logic           isWrite;

  logic [31:0]    addrArr  [NUM_PORTS];
  logic [31:0]    wdataArr [NUM_PORTS];
  logic [GW-1:0]  winner;
  logic [GW-1:0]  idx;
  logic           found;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addrArr[g]  = portAddr[32*g +: 32];
    assign wdataArr[g] = portWData[32*g +: 32];
  end

  // Search starts one past the last winner so every port gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
      idx = GW'((32'(lastGrant) + off) % NUM_PORTS);
      if (!found && portReqValid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lastGrant     <= GW'(NUM_PORTS - 1);
      counter       <= '0;
      guard         <= 1'b0;
      isWrite       <= 1'b0;
      portAccept    <= '0;
      portRspValid  <= '0;
      portRspError  <= 1'b0;
      portRspData   <= '0;
      mcRamAddress  <= '0;
      mcRamIn       <= '0;
      mcReadReq     <= 1'b0;
      mcWriteReq    <= 1'b0;
      mcAddrVirtual <= 1'b0;
      mcExecMode    <= 1'b0;
      arbBusy       <= 1'b0;
      timeoutFlag   <= 1'b0;
    end else begin
      portAccept <= '0;
      mcReadReq  <= 1'b0;
      mcWriteReq <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            mcRamAddress       <= addrArr[winner];
            mcRamIn            <= wdataArr[winner];
            mcAddrVirtual      <= portVirtual[winner];
            mcExecMode         <= portExec[winner];
            mcReadReq          <= ~portWrite[winner];
            mcWriteReq         <= portWrite[winner];
            isWrite            <= portWrite[winner];
            portAccept[winner] <= 1'b1;
            lastGrant          <= winner;
            arbBusy            <= 1'b1;
            guard              <= 1'b1;
            counter            <= '0;
            state              <= WAIT;
          end
        end
        WAIT: begin
          // The controller may still show a stale done from the previous access.
          if (guard) begin
            guard <= 1'b0;
          end else begin
            case (mcStatus)
              2'd2: begin
                portRspValid[lastGrant] <= 1'b1;
                portRspError            <= 1'b0;
                portRspData             <= isWrite ? '0 : mcRamOut;
                state                   <= RESP;
              end
              2'd0: begin
                portRspValid[lastGrant] <= 1'b1;
                portRspError            <= 1'b1;
                portRspData             <= '0;
                state                   <= RESP;
              end
              default: begin
                if (counter == CW'(TIMEOUT_CYCLES - 1)) begin
                  portRspValid[lastGrant] <= 1'b1;
                  portRspError            <= 1'b1;
                  portRspData             <= '0;
                  timeoutFlag             <= 1'b1;
                  state                   <= RESP;
                end else begin
                  counter <= counter + CW'(1);
                end
              end
            endcase
          end
        end
        RESP: begin
          portRspValid <= '0;
          portRspError <= 1'b0;
          portRspData  <= '0;
          counter      <= '0;
          arbBusy      <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed and randomized checks of mc_port_arbiter against a transaction-level model
// of grant order, controller handshake latency and response contents.
module tb_mc_port_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    portReqValid = '0;
  logic [N-1:0]    portWrite = '0;
  logic [32*N-1:0] portAddr = '0;
  logic [32*N-1:0] portWData = '0;
  logic [N-1:0]    portVirtual = '0;
  logic [N-1:0]    portExec = '0;
  logic [N-1:0]    portAccept;
  logic [N-1:0]    portRspValid;
  logic            portRspError;
  logic [31:0]     portRspData;
  logic [31:0]     mcRamAddress;
  logic [31:0]     mcRamIn;
  logic            mcReadReq;
  logic            mcWriteReq;
  logic            mcAddrVirtual;
  logic            mcExecMode;
  logic [31:0]     mcRamOut = '0;
  logic [1:0]      mcStatus = 2'd1;
  logic            arbBusy;
  logic            timeoutFlag;

  mc_port_arbiter #(.NUM_PORTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .portReqValid(portReqValid), .portWrite(portWrite),
    .portAddr(portAddr), .portWData(portWData), .portVirtual(portVirtual), .portExec(portExec),
    .portAccept(portAccept), .portRspValid(portRspValid), .portRspError(portRspError),
    .portRspData(portRspData), .mcRamAddress(mcRamAddress), .mcRamIn(mcRamIn),
    .mcReadReq(mcReadReq), .mcWriteReq(mcWriteReq), .mcAddrVirtual(mcAddrVirtual),
    .mcExecMode(mcExecMode), .mcRamOut(mcRamOut), .mcStatus(mcStatus),
    .arbBusy(arbBusy), .timeoutFlag(timeoutFlag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int   vectors = 0;
  int   miscompares = 0;
  int   last_m = N - 1;
  logic tflag_m = 1'b0;
  int   acc_obs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: lowest requesting port above the previous winner, else lowest requesting port.
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int p = last + 1; p < N; p++) if (v[p]) return p;
    for (int p = 0; p < N; p++) if (v[p]) return p;
    return -1;
  endfunction

  task automatic set_port(input int p, input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic vi, input logic ex);
    portReqValid[p]      = v;
    portWrite[p]         = w;
    portAddr[p*32 +: 32] = a;
    portWData[p*32 +: 32] = d;
    portVirtual[p]       = vi;
    portExec[p]          = ex;
  endtask

  // fin: 2 = done, 0 = error, -1 = controller never finishes.
  task automatic do_txn(input int busy, input logic [1:0] stale, input int fin,
                        input logic [31:0] rdata, input bit drop);
    int           win, cyc, exp_lat;
    logic [N-1:0] exp_acc, exp_rsp;
    logic         ew, ev, ex, eerr;
    logic [31:0]  ea, ed, edata;
    win     = rr_pick(last_m, portReqValid);
    exp_acc = '0;
    exp_acc[win] = 1'b1;
    ew = portWrite[win];
    ea = portAddr[win*32 +: 32];
    ed = portWData[win*32 +: 32];
    ev = portVirtual[win];
    ex = portExec[win];
    mcStatus = stale;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (portAccept != '0) break;
    end
    acc_obs = -1;
    for (int p = 0; p < N; p++) if (portAccept[p]) acc_obs = p;
    chk("accept", 64'(portAccept), 64'(exp_acc));
    chk("strobes", 64'({mcReadReq, mcWriteReq}), 64'({~ew, ew}));
    chk("req_addr", 64'(mcRamAddress), 64'(ea));
    chk("req_wdata", 64'(mcRamIn), 64'(ed));
    chk("req_mode", 64'({mcAddrVirtual, mcExecMode, arbBusy}), 64'({ev, ex, 1'b1}));
    last_m = win;
    if (drop) portReqValid[win] = 1'b0;
    mcRamOut = $urandom;
    cyc = 0;
    forever begin
      if (cyc == 0) mcStatus = stale;
      else if (fin < 0 || cyc <= busy) mcStatus = 2'd1;
      else begin
        mcStatus = 2'(fin);
        mcRamOut = rdata;
      end
      tick();
      cyc++;
      if (portRspValid != '0 || cyc >= 40) break;
      if (cyc == 1) chk("strobe_clear", 64'({mcReadReq, mcWriteReq}), 64'(0));
      chk("addr_held", 64'({mcRamAddress, mcRamIn}), {ea, ed});
    end
    exp_lat = (fin < 0) ? TO + 1 : busy + 2;
    eerr    = (fin != 2);
    edata   = (eerr || ew) ? 32'h0 : rdata;
    if (fin < 0) tflag_m = 1'b1;
    exp_rsp = '0;
    exp_rsp[win] = 1'b1;
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("rsp_valid", 64'(portRspValid), 64'(exp_rsp));
    chk("rsp_err", 64'(portRspError), 64'(eerr));
    chk("rsp_data", 64'(portRspData), 64'(edata));
    chk("rsp_hold", 64'({mcRamAddress, mcRamIn}), {ea, ed});
    chk("tflag_busy", 64'({timeoutFlag, arbBusy}), 64'({tflag_m, 1'b1}));
    mcStatus = 2'd1;
    tick();
    chk("rsp_clear", 64'({portRspValid, arbBusy}), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus"}, {mcRamAddress, mcRamIn}, 64'(0));
    chk({tag, "_data"}, 64'(portRspData), 64'(0));
    chk({tag, "_ctl"}, 64'({portAccept, portRspValid, portRspError, mcReadReq, mcWriteReq,
                            mcAddrVirtual, mcExecMode, arbBusy, timeoutFlag}), 64'(0));
  endtask

  task automatic rr_burst();
    int order [4];
    set_port(0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b0);
    set_port(1, 1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_txn(k, 2'd1, 2, 32'hA000_0000 + 32'(k), 1'b0);
      order[k] = acc_obs;
    end
    portReqValid = '0;
    chk("rr_order", 64'({4'(order[0]), 4'(order[1]), 4'(order[2]), 4'(order[3])}), 64'h0101);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    set_port(0, 1'b1, 1'b0, 32'h0040_1004, 32'h0, 1'b1, 1'b0);
    do_txn(0, 2'd1, 2, 32'hDEAD_BEEF, 1'b1);

    set_port(1, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_55AA, 1'b0, 1'b1);
    do_txn(1, 2'd1, 0, 32'hFFFF_FFFF, 1'b1);

    set_port(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0);
    do_txn(3, 2'd2, 2, 32'h0BAD_F00D, 1'b1);

    set_port(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 1'b0);
    do_txn(0, 2'd1, -1, 32'h1111_1111, 1'b1);

    set_port(0, 1'b1, 1'b1, 32'h0000_00C0, 32'hCAFE_0001, 1'b0, 1'b0);
    do_txn(2, 2'd1, 2, 32'h2222_2222, 1'b1);

    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] pat;
      pat = N'($urandom_range(3, 1));
      for (int p = 0; p < N; p++)
        set_port(p, pat[p], 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      do_txn(int'($urandom_range(4)), ($urandom_range(1) != 0) ? 2'd2 : 2'd1,
             ($urandom_range(1) != 0) ? 2 : 0, $urandom, 1'b1);
    end

    set_port(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (portAccept != '0) break;
    end
    chk("pre_abort_busy", 64'(arbBusy), 64'(1));
    portReqValid = '0;
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("abort");
    last_m  = N - 1;
    tflag_m = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    rr_burst();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
